// File: rtl/mips_fetch_stage.sv
// MIPS IF stage: PC, single-outstanding imem fetch, hold buffer, IF/ID register.
// Optional IF_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        drop, drop_n;
  logic        hold_v, hold_v_n;
  logic [31:0] hold_d, hold_d_n;
  logic        ifid_v_n;
  logic [31:0] ifid_pc_n;
  logic [31:0] ifid_instr_n;
  logic [31:0] pc_inc;
  logic        ifid_free;
  state_t      after_fetch;

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign pc_inc    = pc + 32'd4;
  assign ifid_free = !ifid_valid || !stall;
  assign after_fetch = en ? REQ : IDLE;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      drop       <= 1'b0;
      hold_v     <= 1'b0;
      hold_d     <= 32'd0;
      ifid_valid <= 1'b0;
      ifid_pc    <= 32'd0;
      ifid_instr <= 32'd0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      drop       <= drop_n;
      hold_v     <= hold_v_n;
      hold_d     <= hold_d_n;
      ifid_valid <= ifid_v_n;
      ifid_pc    <= ifid_pc_n;
      ifid_instr <= ifid_instr_n;
    end
  end

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    drop_n       = drop;
    hold_v_n     = hold_v;
    hold_d_n     = hold_d;
    ifid_v_n     = ifid_valid && stall;
    ifid_pc_n    = ifid_pc;
    ifid_instr_n = ifid_instr;
    if (redirect_valid) begin
      // Redirect overrides everything, even a stalled IF/ID.
      ifid_v_n = 1'b0;
      hold_v_n = 1'b0;
      pc_n     = redirect_pc & ~32'h3;
      unique case (state)
        IDLE: state_n = en ? REQ : IDLE;
        REQ: begin
          if (imem_gnt) begin
            state_n = WAIT;
            drop_n  = 1'b1;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            state_n = REQ;
            drop_n  = 1'b0;
          end else begin
            drop_n  = 1'b1;
          end
        end
        HOLD: state_n = REQ;
        default: state_n = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (en) state_n = REQ;
        end
        REQ: begin
          if (imem_gnt) state_n = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop_n  = 1'b0;
              state_n = after_fetch;
            end else if (ifid_free) begin
              ifid_v_n     = 1'b1;
              ifid_pc_n    = pc;
              ifid_instr_n = imem_rdata;
              pc_n         = pc_inc;
              state_n      = after_fetch;
            end else begin
              hold_v_n = 1'b1;
              hold_d_n = imem_rdata;
              state_n  = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_v_n     = 1'b1;
            ifid_pc_n    = pc;
            ifid_instr_n = hold_d;
            hold_v_n     = 1'b0;
            pc_n         = pc_inc;
            state_n      = after_fetch;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef IF_PERF_CNT_EN
  logic load;
  logic stalled;

  // A load is a live IF/ID next cycle that is not just a held entry.
  assign load    = ifid_v_n && !(ifid_valid && stall);
  assign stalled = ifid_valid && stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched <= 32'd0;
      perf_stall   <= 32'd0;
    end else begin
      perf_fetched <= perf_fetched + {31'd0, load};
      perf_stall   <= perf_stall + {31'd0, stalled};
    end
  end
`else
  assign perf_fetched = 32'd0;
  assign perf_stall   = 32'd0;
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage with a small imem responder.
// Responder knobs: gnt_en gates grant, rsp_delay delays rvalid after grant.
module tb_mips_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;

  int total = 0;
  int bad   = 0;

  logic        gnt_en = 1'b1;
  int          rsp_delay = 0;
  logic        pend = 1'b0;
  logic [31:0] paddr = 32'd0;
  int          cnt = 0;

  mips_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .ifid_valid     (ifid_valid),
    .ifid_pc        (ifid_pc),
    .ifid_instr     (ifid_instr),
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
  );

  always #5 clk = ~clk;

  assign imem_gnt    = imem_req & gnt_en;
  assign imem_rvalid = pend && (cnt == 0);
  assign imem_rdata  = imem_rvalid ? (paddr ^ 32'hC0DE_0000) : 32'd0;

  always @(posedge clk) begin
    if (imem_rvalid) pend <= 1'b0;
    else if (pend) cnt <= cnt - 1;
    if (imem_gnt) begin
      pend  <= 1'b1;
      paddr <= imem_addr;
      cnt   <= rsp_delay;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_perf(input string tag, input logic [31:0] f,
                          input logic [31:0] s);
`ifdef IF_PERF_CNT_EN
    chk({tag, "_fetched"}, perf_fetched, f);
    chk({tag, "_stall"}, perf_stall, s);
`else
    chk({tag, "_fetched"}, perf_fetched, 32'd0 & f);
    chk({tag, "_stall"}, perf_stall, 32'd0 & s);
`endif
  endtask

  initial begin
    rst = 1'b0;
    en = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    cyc(2);
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_pc", ifid_pc, 32'd0);
    chk("rst_instr", ifid_instr, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h3000);
    chk_perf("rst_perf", 32'd0, 32'd0);

    rst = 1'b1;
    en = 1'b1;
    cyc(1);
    chk("f0_req", {31'd0, imem_req}, 32'd1);
    chk("f0_addr", imem_addr, 32'h3000);
    cyc(1);
    chk("f0_wait_req", {31'd0, imem_req}, 32'd0);
    chk("f0_wait_valid", {31'd0, ifid_valid}, 32'd0);
    cyc(1);
    chk("f0_valid", {31'd0, ifid_valid}, 32'd1);
    chk("f0_pc", ifid_pc, 32'h3000);
    chk("f0_instr", ifid_instr, 32'hC0DE_3000);
    chk("f1_addr", imem_addr, 32'h3004);
    cyc(2);
    chk("f1_pc", ifid_pc, 32'h3004);
    chk("f1_instr", ifid_instr, 32'hC0DE_3004);
    cyc(2);
    chk("f2_pc", ifid_pc, 32'h3008);
    chk("f3_addr", imem_addr, 32'h300C);

    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("stall_valid", {31'd0, ifid_valid}, 32'd1);
      chk("stall_pc", ifid_pc, 32'h3008);
      chk("stall_instr", ifid_instr, 32'hC0DE_3008);
    end
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    cyc(1);
    chk("unhold_pc", ifid_pc, 32'h300C);
    chk("unhold_instr", ifid_instr, 32'hC0DE_300C);
    chk("unhold_addr", imem_addr, 32'h3010);
    chk("unhold_req", {31'd0, imem_req}, 32'd1);
    chk_perf("perf_a", 32'd4, 32'd5);

    rsp_delay = 2;
    cyc(1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h4008;
    cyc(1);
    redirect_valid = 1'b0;
    chk("rdw_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rdw_req", {31'd0, imem_req}, 32'd0);
    cyc(2);
    chk("rdw_req2", {31'd0, imem_req}, 32'd1);
    chk("rdw_addr", imem_addr, 32'h4008);
    chk("rdw_valid2", {31'd0, ifid_valid}, 32'd0);
    rsp_delay = 0;
    cyc(2);
    chk("rdw_pc", ifid_pc, 32'h4008);
    chk("rdw_instr", ifid_instr, 32'hC0DE_4008);
    chk("rdw_addr2", imem_addr, 32'h400C);

    redirect_valid = 1'b1;
    redirect_pc = 32'h4003;
    cyc(1);
    redirect_valid = 1'b0;
    chk("rdg_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rdg_req", {31'd0, imem_req}, 32'd0);
    cyc(1);
    chk("rdg_req2", {31'd0, imem_req}, 32'd1);
    chk("rdg_addr", imem_addr, 32'h4000);
    cyc(2);
    chk("rdg_pc", ifid_pc, 32'h4000);
    chk("rdg_instr", ifid_instr, 32'hC0DE_4000);
    chk("rdg_addr2", imem_addr, 32'h4004);

    gnt_en = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc(1);
    redirect_valid = 1'b0;
    gnt_en = 1'b1;
    chk("rdr_req", {31'd0, imem_req}, 32'd1);
    chk("rdr_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(2);
    chk("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", ifid_instr, 32'h3F21_FFFC);
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    chk("wrap_req", {31'd0, imem_req}, 32'd1);
    chk_perf("perf_b", 32'd7, 32'd5);

    rsp_delay = 1;
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("mrst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("mrst_pc", ifid_pc, 32'd0);
    chk("mrst_instr", ifid_instr, 32'd0);
    chk("mrst_req", {31'd0, imem_req}, 32'd0);
    chk("mrst_addr", imem_addr, 32'h3000);
    chk_perf("mrst_perf", 32'd0, 32'd0);
    rst = 1'b1;
    en = 1'b0;
    cyc(1);
    chk("stray_valid", {31'd0, ifid_valid}, 32'd0);
    chk("stray_req", {31'd0, imem_req}, 32'd0);
    chk("stray_addr", imem_addr, 32'h3000);
    en = 1'b1;
    rsp_delay = 0;
    cyc(1);
    chk("re_req", {31'd0, imem_req}, 32'd1);
    chk("re_addr", imem_addr, 32'h3000);
    cyc(2);
    chk("re_valid", {31'd0, ifid_valid}, 32'd1);
    chk("re_pc", ifid_pc, 32'h3000);
    chk("re_instr", ifid_instr, 32'hC0DE_3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
